md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit_pkg.sv | 33 +++
 rtl/md_unit_latency_counter.sv | 30 +++
 rtl/md_unit.sv | 139 +++++++++++++
 tb/tb_md_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared CPU package slice: multiply/divide op encodings and latencies.
// MDU_MADD_EN enables MADD/MADDU as multiply-class ops.
package md_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } md_op_e;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MUL_LAT = 4'd5;
  localparam logic [CNT_W-1:0] DIV_LAT = 4'd10;

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mul(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_MADD) || (op == OP_MADDU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

endpackage

// File: rtl/md_unit_latency_counter.sv
// Load/decrement latency counter for the MD unit.
// busy and done decode the count register only, never the load input.
module md_latency_counter
  import md_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_lat,
  output logic             o_busy,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_lat;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Last busy cycle: results commit on the edge that clears busy.
  assign o_busy = (r_cnt != '0);
  assign o_done = (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO and fixed-latency busy.
// MDU_MADD_EN enables MADD/MADDU accumulate into {hi,lo}.
module md_unit
  import md_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] r_hi = '0;
  logic [31:0] r_lo = '0;
  logic [31:0] r_a  = '0;
  logic [31:0] r_b  = '0;
  md_op_e      r_op = OP_MULT;

  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic             w_load;
  logic [CNT_W-1:0] w_lat;

  assign w_accept = start & ~w_busy;
  assign w_load   = w_accept & (is_mul(md_op) | is_div(md_op));
  assign w_lat    = is_div(md_op) ? DIV_LAT : MUL_LAT;

  md_latency_counter u_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_lat  (w_lat),
    .o_busy (w_busy),
    .o_done (w_done)
  );

  logic signed [63:0] w_sa;
  logic signed [63:0] w_sb;
  logic        [63:0] w_mul_s;
  logic        [63:0] w_mul_u;

  assign w_sa    = {{32{r_a[31]}}, r_a};
  assign w_sb    = {{32{r_b[31]}}, r_b};
  assign w_mul_s = w_sa * w_sb;
  assign w_mul_u = {32'd0, r_a} * {32'd0, r_b};

  // 33-bit signed divide keeps 0x80000000 / -1 representable.
  logic signed [32:0] w_dsa;
  logic signed [32:0] w_dsb;
  logic signed [32:0] w_qs;
  logic signed [32:0] w_rs;
  logic        [31:0] w_qu;
  logic        [31:0] w_ru;
  logic               w_unused;

  assign w_dsa    = {r_a[31], r_a};
  assign w_dsb    = {r_b[31], r_b};
  assign w_qs     = w_dsa / w_dsb;
  assign w_rs     = w_dsa % w_dsb;
  assign w_qu     = r_a / r_b;
  assign w_ru     = r_a % r_b;
  assign w_unused = w_qs[32] ^ w_rs[32];

  logic        w_wr;
  logic [63:0] w_res;

  always_comb begin
    w_wr  = 1'b0;
    w_res = '0;
    case (r_op)
      OP_MULT: begin
        w_wr  = 1'b1;
        w_res = w_mul_s;
      end
      OP_MULTU: begin
        w_wr  = 1'b1;
        w_res = w_mul_u;
      end
      OP_DIV: begin
        w_wr  = (r_b != '0);
        w_res = {w_rs[31:0], w_qs[31:0]};
      end
      OP_DIVU: begin
        w_wr  = (r_b != '0);
        w_res = {w_ru, w_qu};
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        w_wr  = 1'b1;
        w_res = {r_hi, r_lo} + w_mul_s;
      end
      OP_MADDU: begin
        w_wr  = 1'b1;
        w_res = {r_hi, r_lo} + w_mul_u;
      end
`endif
      default: begin
        w_wr  = 1'b0;
        w_res = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
      r_a  <= '0;
      r_b  <= '0;
      r_op <= OP_MULT;
    end else begin
      if (w_load) begin
        r_op <= md_op_e'(md_op);
        r_a  <= rs_val;
        r_b  <= rt_val;
      end
      if (w_accept && md_op == OP_MTHI) begin
        r_hi <= rs_val;
      end
      if (w_accept && md_op == OP_MTLO) begin
        r_lo <= rs_val;
      end
      if (w_done && w_wr) begin
        r_hi <= w_res[63:32];
        r_lo <= w_res[31:0];
      end
    end
  end

  assign busy = w_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit against an arithmetic HI/LO model.
// Define MDU_MADD_EN here as for the RTL to check the accumulate build.
module tb_md_unit;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        start  = 1'b0;
  logic [2:0]  md_op  = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one op on HI/LO, plus its busy length.
  task automatic model(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    longint sa, sb;
    logic [63:0] pu;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    pu  = 64'(a) * 64'(b);
    lat = 0;
    case (op)
      3'd0: begin {m_hi, m_lo} = sa * sb; lat = 5; end
      3'd1: begin {m_hi, m_lo} = pu; lat = 5; end
      3'd2: begin
        lat = 10;
        if (b != 0) begin
          m_lo = 32'(sa / sb);
          m_hi = 32'(sa % sb);
        end
      end
      3'd3: begin
        lat = 10;
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
`ifdef MDU_MADD_EN
      3'd6: begin {m_hi, m_lo} = {m_hi, m_lo} + 64'(sa * sb); lat = 5; end
      3'd7: begin {m_hi, m_lo} = {m_hi, m_lo} + pu; lat = 5; end
`endif
      default: lat = 0;
    endcase
  endtask

  // Called at a negedge with busy low; returns at the first idle negedge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    int lat, n;
    model(op, a, b, lat);
    md_op  = op;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(n), 64'(lat));
    chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    int lat, n;
    logic bad;
    logic [2:0]  op;
    logic [31:0] a, b;

    #1;
    chk("powerup_busy", 64'(busy), 64'd0);
    chk("powerup_hi", 64'(hi), 64'd0);
    chk("powerup_lo", 64'(lo), 64'd0);

    // Reset with a competing start: reset wins.
    @(negedge clk);
    reset  = 1'b1;
    start  = 1'b1;
    md_op  = 3'd2;
    rs_val = 32'd100;
    rt_val = 32'd7;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    chk("reset_start_ignored", 64'(busy), 64'd0);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    chk("mult_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFFA);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    chk("div_neg_lo_const", 64'(lo), 64'hFFFF_FFFD);
    chk("div_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);

    run_op(3'd3, 32'd1234, 32'd0, "divu_zero");
    chk("divu_zero_lo_kept", 64'(lo), 64'hFFFF_FFFD);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi_const", 64'(hi), 64'd0);

    run_op(3'd4, 32'h1234_5678, 32'd0, "mthi");
    run_op(3'd5, 32'h9ABC_DEF0, 32'd0, "mtlo");
    chk("mt_hi_const", 64'(hi), 64'h1234_5678);

    // Second start two cycles into busy must be ignored.
    a = $urandom;
    b = $urandom;
    model(3'd1, a, b, lat);
    md_op  = 3'd1;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 2) begin
        md_op  = 3'd2;
        rs_val = $urandom;
        rt_val = $urandom | 32'd1;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignore_busy_cycles", 64'(n), 64'(lat));
    chk("ignore_hi", 64'(hi), 64'(m_hi));
    chk("ignore_lo", 64'(lo), 64'(m_lo));

    // Reset in the fourth busy cycle of a divide.
    md_op  = 3'd2;
    rs_val = 32'd1000;
    rt_val = 32'd3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== '0 || lo !== '0) bad = 1'b1;
    end
    chk("abort_no_late_wb", 64'(bad), 64'd0);

    run_op(3'd0, 32'd2, 32'd3, "madd_pre");
    run_op(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "madd");
`ifdef MDU_MADD_EN
    chk("madd_lo_const", 64'(lo), 64'd7);
`else
    chk("madd_lo_const", 64'(lo), 64'd6);
`endif
    chk("madd_hi_const", 64'(hi), 64'd0);

    repeat (40) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      run_op(op, a, b, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
